// File: rtl/lc3_dual_mem_responder.sv
// ---------------------------------------------------------------------------
// lc3_dual_mem_responder
//
// Unified word memory shared by two independent request channels of an LC3
// core: an instruction-fetch channel (read only) and a data channel
// (read/write). Each channel runs its own IDLE/WAIT/DONE wait-state machine
// with a fixed latency. A one-cycle completion pulse, and an address-range
// error flag, are issued for every accepted request. Both channels run
// concurrently against the same array, and neither one stalls the other.
//
// Ports
//   clock, reset       rising-edge clock, synchronous active-high reset
//   I_macc, instrmem_rd instruction request; accepted only when both are 1
//   pc                 instruction address
//   Instr_dout         fetched word, held until the next fetch completes
//   complete_instr     one-cycle instruction completion pulse
//   I_err              instruction address had bits above the index field
//   D_macc             data request valid
//   Data_rd            1 = read, 0 = write
//   Data_addr          data address
//   Data_din           write data
//   Data_dout          read data, held until the next data read completes
//   complete_data      one-cycle data completion pulse
//   D_err              data address had bits above the index field
// ---------------------------------------------------------------------------
module lc3_dual_mem_responder #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 16,
    parameter int DEPTH_LOG2 = 8,
    parameter int I_LAT      = 0,
    parameter int D_LAT      = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              I_macc,
    input  logic              instrmem_rd,
    input  logic [ADDR_W-1:0] pc,
    output logic [DATA_W-1:0] Instr_dout,
    output logic              complete_instr,
    input  logic              D_macc,
    input  logic              Data_rd,
    input  logic [ADDR_W-1:0] Data_addr,
    input  logic [DATA_W-1:0] Data_din,
    output logic [DATA_W-1:0] Data_dout,
    output logic              complete_data,
    output logic              I_err,
    output logic              D_err
);

    localparam int         DEPTH   = 1 << DEPTH_LOG2;
    localparam bit         I_ZERO  = (I_LAT == 0);
    localparam bit         D_ZERO  = (D_LAT == 0);
    localparam logic [3:0] I_LAT_C = 4'(I_LAT);
    localparam logic [3:0] D_LAT_C = 4'(D_LAT);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DONE
    } state_t;

    logic [DATA_W-1:0] r_mem [DEPTH];

    state_t                r_iState;
    logic [3:0]            r_iCnt;
    logic [DEPTH_LOG2-1:0] r_iIdx;
    logic                  r_iHigh;

    state_t                r_dState;
    logic [3:0]            r_dCnt;
    logic [DEPTH_LOG2-1:0] r_dIdx;
    logic                  r_dHigh;
    logic                  r_dRd;
    logic [DATA_W-1:0]     r_dDin;

    logic                  w_iAccept;
    logic                  w_iHigh;
    logic                  w_iEnter;
    logic [DEPTH_LOG2-1:0] w_iCurIdx;

    logic                  w_dAccept;
    logic                  w_dHigh;
    logic                  w_dEnter;
    logic [DEPTH_LOG2-1:0] w_dCurIdx;
    logic                  w_dCurRd;
    logic [DATA_W-1:0]     w_dCurDin;

    // Request acceptance and out-of-range detection. Any address bit above
    // the index field flags an error, but the access still uses the wrapped
    // index.
    assign w_iAccept = I_macc && instrmem_rd;
    assign w_dAccept = D_macc;
    assign w_iHigh   = |(pc >> DEPTH_LOG2);
    assign w_dHigh   = |(Data_addr >> DEPTH_LOG2);

    // "Enter" marks the edge on which a transaction moves into DONE. With
    // zero latency that is the acceptance edge itself, so the live inputs
    // are used; otherwise the values captured at acceptance are used.
    assign w_iEnter  = !reset &&
                       ((r_iState == ST_IDLE && w_iAccept && I_ZERO) ||
                        (r_iState == ST_WAIT && r_iCnt == 4'd1));
    assign w_iCurIdx = (r_iState == ST_IDLE) ? pc[DEPTH_LOG2-1:0] : r_iIdx;

    assign w_dEnter  = !reset &&
                       ((r_dState == ST_IDLE && w_dAccept && D_ZERO) ||
                        (r_dState == ST_WAIT && r_dCnt == 4'd1));
    assign w_dCurIdx = (r_dState == ST_IDLE) ? Data_addr[DEPTH_LOG2-1:0] : r_dIdx;
    assign w_dCurRd  = (r_dState == ST_IDLE) ? Data_rd  : r_dRd;
    assign w_dCurDin = (r_dState == ST_IDLE) ? Data_din : r_dDin;

    // Memory array: never reset. A data write lands on the edge entering
    // DONE; an instruction read on that same edge sees the old word because
    // it samples the array before this non-blocking update takes effect.
    always_ff @(posedge clock) begin
        if (w_dEnter && !w_dCurRd) begin
            r_mem[w_dCurIdx] <= w_dCurDin;
        end
    end

    // Instruction channel FSM. The completion pulse and error flag are
    // registered on the edge that leaves DONE, so they appear in the cycle
    // after DONE, while the read data is already valid.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_iState       <= ST_IDLE;
            r_iCnt         <= 4'd0;
            r_iIdx         <= '0;
            r_iHigh        <= 1'b0;
            Instr_dout     <= '0;
            complete_instr <= 1'b0;
            I_err          <= 1'b0;
        end else begin
            complete_instr <= 1'b0;
            I_err          <= 1'b0;
            if (w_iEnter) begin
                Instr_dout <= r_mem[w_iCurIdx];
            end
            case (r_iState)
                ST_IDLE: begin
                    if (w_iAccept) begin
                        r_iIdx   <= pc[DEPTH_LOG2-1:0];
                        r_iHigh  <= w_iHigh;
                        r_iCnt   <= I_LAT_C;
                        r_iState <= I_ZERO ? ST_DONE : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    r_iCnt <= r_iCnt - 4'd1;
                    if (r_iCnt == 4'd1) begin
                        r_iState <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    complete_instr <= 1'b1;
                    I_err          <= r_iHigh;
                    r_iState       <= ST_IDLE;
                end
                default: r_iState <= ST_IDLE;
            endcase
        end
    end

    // Data channel FSM. Same structure as the instruction channel, but it
    // also captures direction and write data at acceptance. A reset while
    // in WAIT returns to IDLE before the write edge, dropping the write.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_dState      <= ST_IDLE;
            r_dCnt        <= 4'd0;
            r_dIdx        <= '0;
            r_dHigh       <= 1'b0;
            r_dRd         <= 1'b0;
            r_dDin        <= '0;
            Data_dout     <= '0;
            complete_data <= 1'b0;
            D_err         <= 1'b0;
        end else begin
            complete_data <= 1'b0;
            D_err         <= 1'b0;
            if (w_dEnter && w_dCurRd) begin
                Data_dout <= r_mem[w_dCurIdx];
            end
            case (r_dState)
                ST_IDLE: begin
                    if (w_dAccept) begin
                        r_dIdx   <= Data_addr[DEPTH_LOG2-1:0];
                        r_dHigh  <= w_dHigh;
                        r_dRd    <= Data_rd;
                        r_dDin   <= Data_din;
                        r_dCnt   <= D_LAT_C;
                        r_dState <= D_ZERO ? ST_DONE : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    r_dCnt <= r_dCnt - 4'd1;
                    if (r_dCnt == 4'd1) begin
                        r_dState <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    complete_data <= 1'b1;
                    D_err         <= r_dHigh;
                    r_dState      <= ST_IDLE;
                end
                default: r_dState <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lc3_dual_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_lc3_dual_mem_responder
//
// Scoreboard bench. Stimulus tasks push the expected completion (cycle,
// data word, error flag) into one queue per channel as each request is
// issued. A monitor pops and compares whenever a completion pulse is seen.
// The reference memory is a time-stamped log of writes. A read returns the
// latest write that landed strictly before the read's own landing edge.
// ---------------------------------------------------------------------------
module tb_lc3_dual_mem_responder;

    localparam int DATA_W     = 16;
    localparam int ADDR_W     = 16;
    localparam int DEPTH_LOG2 = 8;
    localparam int I_LAT      = 0;
    localparam int D_LAT      = 2;
    localparam int DEPTH      = 1 << DEPTH_LOG2;

    logic              clock;
    logic              reset;
    logic              I_macc;
    logic              instrmem_rd;
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] Instr_dout;
    logic              complete_instr;
    logic              D_macc;
    logic              Data_rd;
    logic [ADDR_W-1:0] Data_addr;
    logic [DATA_W-1:0] Data_din;
    logic [DATA_W-1:0] Data_dout;
    logic              complete_data;
    logic              I_err;
    logic              D_err;

    lc3_dual_mem_responder #(
        .DATA_W     (DATA_W),
        .ADDR_W     (ADDR_W),
        .DEPTH_LOG2 (DEPTH_LOG2),
        .I_LAT      (I_LAT),
        .D_LAT      (D_LAT)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .I_macc         (I_macc),
        .instrmem_rd    (instrmem_rd),
        .pc             (pc),
        .Instr_dout     (Instr_dout),
        .complete_instr (complete_instr),
        .D_macc         (D_macc),
        .Data_rd        (Data_rd),
        .Data_addr      (Data_addr),
        .Data_din       (Data_din),
        .Data_dout      (Data_dout),
        .complete_data  (complete_data),
        .I_err          (I_err),
        .D_err          (D_err)
    );

    // Free-running clock and a count of rising edges seen.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int nChecks = 0;
    int nFails  = 0;

    typedef struct {
        int                cycle;
        logic [DATA_W-1:0] dout;
        logic              err;
    } exp_t;

    typedef struct {
        int                land;
        int                idx;
        logic [DATA_W-1:0] data;
    } wr_t;

    exp_t iQ[$];
    exp_t dQ[$];
    wr_t  wrLog[$];
    logic [DATA_W-1:0] lastDataRead = '0;

    // Memory contents seen by an access landing on edge 'land'.
    function automatic logic [DATA_W-1:0] memAt(int idx, int land);
        for (int k = wrLog.size() - 1; k >= 0; k--) begin
            if (wrLog[k].idx == idx && wrLog[k].land < land) return wrLog[k].data;
        end
        return '0;
    endfunction

    function automatic logic [DATA_W-1:0] preloadVal(int i);
        case (i)
            0:       return 16'h1021;
            1:       return 16'h1422;
            2:       return 16'h0FFE;
            'h20:    return 16'h1111;
            'h30:    return 16'h0000;
            default: return DATA_W'($urandom);
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // Drive ignorable values. While the channel is busy a raw valid may be
    // present; on the idle edge an instruction request is gated off and a
    // data request is withdrawn.
    task automatic scramble(input bit isInstr, input bit busy);
        if (isInstr) begin
            I_macc      = 1'($urandom);
            instrmem_rd = busy ? 1'($urandom) : 1'b0;
            pc          = ADDR_W'($urandom);
        end else begin
            D_macc    = busy ? 1'($urandom) : 1'b0;
            Data_rd   = 1'($urandom);
            Data_addr = ADDR_W'($urandom);
            Data_din  = DATA_W'($urandom);
        end
    endtask

    // Issue one request on a channel and push its expected completion. The
    // request is accepted on the edge following the drive negedge.
    task automatic applyStimulus(input bit isInstr, input bit rd,
                                 input logic [ADDR_W-1:0] addr,
                                 input logic [DATA_W-1:0] din, input int gap);
        int   lat;
        int   t;
        int   idx;
        logic err;
        lat = isInstr ? I_LAT : D_LAT;
        idx = int'(addr) % DEPTH;
        err = (int'(addr) >= DEPTH);
        @(negedge clock);
        t = cyc + 1;
        if (isInstr) begin
            I_macc      = 1'b1;
            instrmem_rd = 1'b1;
            pc          = addr;
            iQ.push_back('{t + 1 + lat, memAt(idx, t + lat), err});
        end else begin
            D_macc    = 1'b1;
            Data_rd   = rd;
            Data_addr = addr;
            Data_din  = din;
            if (rd) lastDataRead = memAt(idx, t + lat);
            else    wrLog.push_back('{t + lat, idx, din});
            dQ.push_back('{t + 1 + lat, lastDataRead, err});
        end
        repeat (lat + 1) begin
            @(negedge clock);
            scramble(isInstr, 1'b1);
        end
        @(negedge clock);
        scramble(isInstr, 1'b0);
        repeat (gap) @(negedge clock);
    endtask

    // Hold the fetch request continuously, stepping pc after each
    // acceptance; acceptances fall every I_LAT+2 cycles.
    task automatic fetchBurst(input logic [ADDR_W-1:0] start, input int n);
        int t0;
        @(negedge clock);
        I_macc      = 1'b1;
        instrmem_rd = 1'b1;
        pc          = start;
        t0          = cyc + 1;
        for (int k = 0; k < n; k++) begin
            int                tk;
            logic [ADDR_W-1:0] a;
            tk = t0 + k * (I_LAT + 2);
            a  = start + ADDR_W'(k);
            iQ.push_back('{tk + 1 + I_LAT, memAt(int'(a) % DEPTH, tk + I_LAT),
                           int'(a) >= DEPTH});
            while (cyc < tk) @(negedge clock);
            if (k == n - 1) begin
                I_macc      = 1'b0;
                instrmem_rd = 1'b0;
            end else begin
                pc = start + ADDR_W'(k + 1);
            end
        end
        repeat (I_LAT + 2) @(negedge clock);
    endtask

    // Monitor: every completion pulse must match the head of its queue.
    always @(negedge clock) begin
        exp_t e;
        if (complete_data) begin
            if (dQ.size() == 0) begin
                nChecks++;
                nFails++;
                $display("[TB] FAIL data_unexpected_complete: got pulse, expected none (cycle %0d)", cyc);
            end else begin
                e = dQ.pop_front();
                checkOutput("data_cycle", cyc, e.cycle);
                checkOutput("Data_dout", Data_dout, e.dout);
                checkOutput("D_err", D_err, e.err);
            end
        end
        if (complete_instr) begin
            if (iQ.size() == 0) begin
                nChecks++;
                nFails++;
                $display("[TB] FAIL instr_unexpected_complete: got pulse, expected none (cycle %0d)", cyc);
            end else begin
                e = iQ.pop_front();
                checkOutput("instr_cycle", cyc, e.cycle);
                checkOutput("Instr_dout", Instr_dout, e.dout);
                checkOutput("I_err", I_err, e.err);
            end
        end
    end

    // Safety net so the run always ends.
    initial begin
        #500000;
        nFails++;
        $display("[TB] FAIL watchdog: got timeout, expected completion of all tests");
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

    initial begin
        reset       = 1'b1;
        I_macc      = 1'b0;
        instrmem_rd = 1'b0;
        pc          = '0;
        D_macc      = 1'b0;
        Data_rd     = 1'b0;
        Data_addr   = '0;
        Data_din    = '0;

        $display("[TB] reset and idle");
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        checkOutput("rst_complete_instr", complete_instr, 0);
        checkOutput("rst_complete_data", complete_data, 0);
        checkOutput("rst_Instr_dout", Instr_dout, 0);
        checkOutput("rst_Data_dout", Data_dout, 0);
        checkOutput("rst_I_err", I_err, 0);
        checkOutput("rst_D_err", D_err, 0);
        repeat (10) @(negedge clock);

        $display("[TB] preload memory");
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b0, 1'b0, ADDR_W'(i), preloadVal(i), 0);
        end

        $display("[TB] data write then read");
        applyStimulus(1'b0, 1'b0, 16'h0012, 16'hBEEF, 1);
        applyStimulus(1'b0, 1'b1, 16'h0012, 16'h0000, 1);
        checkOutput("read_beef", Data_dout, 16'hBEEF);

        $display("[TB] zero-latency fetch burst");
        fetchBurst(16'h0000, 3);
        checkOutput("burst_last", Instr_dout, 16'h0FFE);

        $display("[TB] wrap and error");
        applyStimulus(1'b0, 1'b0, 16'h0105, 16'h5A5A, 1);
        applyStimulus(1'b0, 1'b1, 16'h0005, 16'h0000, 1);
        checkOutput("wrap_read", Data_dout, 16'h5A5A);

        $display("[TB] same-edge conflict");
        fork
            applyStimulus(1'b0, 1'b0, 16'h0020, 16'h2222, 0);
            begin
                repeat (2) @(negedge clock);
                applyStimulus(1'b1, 1'b0, 16'h0020, 16'h0000, 0);
            end
        join
        checkOutput("conflict_old", Instr_dout, 16'h1111);
        applyStimulus(1'b1, 1'b0, 16'h0020, 16'h0000, 1);
        checkOutput("conflict_new", Instr_dout, 16'h2222);

        $display("[TB] reset mid-write");
        @(negedge clock);
        D_macc    = 1'b1;
        Data_rd   = 1'b0;
        Data_addr = 16'h0030;
        Data_din  = 16'hDEAD;
        @(negedge clock);
        D_macc = 1'b0;
        reset  = 1'b1;
        @(negedge clock);
        reset        = 1'b0;
        lastDataRead = '0;
        checkOutput("midrst_Data_dout", Data_dout, 0);
        repeat (6) @(negedge clock);
        applyStimulus(1'b0, 1'b1, 16'h0030, 16'h0000, 1);
        checkOutput("midrst_read", Data_dout, 16'h0000);

        $display("[TB] random concurrent traffic");
        fork
            for (int n = 0; n < 40; n++) begin
                logic [ADDR_W-1:0] a;
                a = ($urandom_range(0, 3) == 0) ? ADDR_W'($urandom)
                                                : ADDR_W'($urandom_range(0, DEPTH - 1));
                applyStimulus(1'b0, 1'($urandom), a, DATA_W'($urandom),
                              int'($urandom_range(0, 2)));
            end
            for (int n = 0; n < 40; n++) begin
                logic [ADDR_W-1:0] a;
                a = ($urandom_range(0, 3) == 0) ? ADDR_W'($urandom)
                                                : ADDR_W'($urandom_range(0, DEPTH - 1));
                applyStimulus(1'b1, 1'b0, a, '0, int'($urandom_range(0, 2)));
            end
        join

        for (int w = 0; w < 50 && (iQ.size() != 0 || dQ.size() != 0); w++) begin
            @(negedge clock);
        end
        checkOutput("instr_queue_drained", iQ.size(), 0);
        checkOutput("data_queue_drained", dQ.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
